// File: rtl/seq_shift_left.sv
// Multi-cycle arithmetic left shifter: one bit per clock, start/busy/done handshake,
// signed-overflow detection. Define SHIFT_SATURATE_EN to clamp overflowed results.
module seq_shift_left #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             ovfl,
    output logic             zero
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovfl_q, ovfl_d;
    logic             zero_q, zero_d;

    // Result-path signals, only meaningful when load_res is set
    logic             load_res;
    logic [WIDTH-1:0] res_val;
    logic             res_ovf;
    logic [WIDTH-1:0] res_final;

`ifdef SHIFT_SATURATE_EN
    localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

    // Operand sign must be kept: acc has lost it by the time overflow is known
    logic sign_q, sign_d;

    always_comb begin
        sign_d = sign_q;
        if ((state_q != StShift) && start) begin
            sign_d = in[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
        end
    end

    assign res_final = res_ovf ? (sign_q ? SatMin : SatMax) : res_val;
`else
    assign res_final = res_val;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        load_res = 1'b0;
        res_val  = '0;
        res_ovf  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    acc_d = in;
                    cnt_d = shamt;
                    ovf_d = 1'b0;
                    if (shamt == '0) begin
                        state_d  = StDone;
                        load_res = 1'b1;
                        res_val  = in;
                        res_ovf  = 1'b0;
                    end else begin
                        state_d = StShift;
                    end
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                acc_d = {acc_q[WIDTH-2:0], 1'b0};
                ovf_d = ovf_q | (acc_q[WIDTH-1] ^ acc_q[WIDTH-2]);
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d  = StDone;
                    load_res = 1'b1;
                    res_val  = acc_d;
                    res_ovf  = ovf_d;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Visible result registers only update on entry into DONE
    always_comb begin
        out_d  = out_q;
        ovfl_d = ovfl_q;
        zero_d = zero_q;
        if (load_res) begin
            out_d  = res_final;
            ovfl_d = res_ovf;
            zero_d = (res_final == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            ovfl_q  <= ovfl_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign out  = out_q;
    assign ovfl = ovfl_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_seq_shift_left.sv
// Self-checking bench for seq_shift_left; an arithmetic reference model predicts result,
// overflow, zero flag and latency. Honours SHIFT_SATURATE_EN like the design.
module tb_seq_shift_left;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] in;
    logic [3:0]  shamt;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        ovfl;
    logic        zero;

    int errors;
    int checks;

    seq_shift_left #(
        .WIDTH(16),
        .SHW  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .in   (in),
        .shamt(shamt),
        .busy (busy),
        .done (done),
        .out  (out),
        .ovfl (ovfl),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: multiply by 2^s; overflow when the product leaves the signed 16-bit range
    function automatic logic [16:0] model(input logic [15:0] a, input logic [3:0] s);
        longint      p;
        logic        ov;
        logic [15:0] r;
        p  = longint'($signed(a)) * (longint'(1) << s);
        ov = (p > 32767) || (p < -32768);
        r  = p[15:0];
`ifdef SHIFT_SATURATE_EN
        if (ov) r = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {ov, r};
    endfunction

    task automatic do_start(input logic [15:0] a, input logic [3:0] s);
        @(negedge clk);
        start = 1'b1;
        in    = a;
        shamt = s;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called just after the accept edge; returns cycles until done (-1 on timeout),
    // and whether busy stayed high and out stayed at prev until done
    task automatic wait_done(input logic [15:0] prev, output int lat, output bit busy_ok,
                             output bit out_ok);
        lat     = -1;
        busy_ok = 1'b1;
        out_ok  = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (out !== prev) out_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, out, ovfl, zero} !== 20'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b out=%h ovfl=%b zero=%b, want all 0",
                     busy, done, out, ovfl, zero);
        end
    endtask

    task automatic test_basic;
        int lat; bit bok; bit ook;
        do_start(16'h0003, 4'd4);
        wait_done(16'h0000, lat, bok, ook);
        checks++;
        if (lat !== 5 || !bok || !ook) begin
            errors++;
            $display("FAIL basic_timing: lat=%0d busy_ok=%b out_ok=%b, want lat=5 1 1",
                     lat, bok, ook);
        end
        checks++;
        if ({out, ovfl, zero} !== {16'h0030, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got %h/%b/%b, want 0030/0/0", out, ovfl, zero);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || out !== 16'h0030) begin
            errors++;
            $display("FAIL done_pulse: done=%b out=%h, want 0 and 0030 held", done, out);
        end
    endtask

    task automatic test_overflow;
        int lat; bit bok; bit ook;
        logic [15:0] exp_out;
`ifdef SHIFT_SATURATE_EN
        exp_out = 16'h7FFF;
`else
        exp_out = 16'h8000;
`endif
        do_start(16'h4000, 4'd1);
        wait_done(16'h0030, lat, bok, ook);
        checks++;
        if (lat !== 2 || {out, ovfl, zero} !== {exp_out, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL overflow_one: lat=%0d got %h/%b/%b, want lat=2 %h/1/0",
                     lat, out, ovfl, zero, exp_out);
        end
    endtask

    task automatic test_zero_shift;
        int lat; bit bok; bit ook;
        do_start(16'hFFF0, 4'd0);
        wait_done(out, lat, bok, ook);
        checks++;
        if (lat !== 1 || !bok || {out, ovfl, zero} !== {16'hFFF0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL shamt_zero: lat=%0d busy_ok=%b got %h/%b/%b, want 1 1 FFF0/0/0",
                     lat, bok, out, ovfl, zero);
        end
        do_start(16'hFFFF, 4'd15);
        wait_done(16'hFFF0, lat, bok, ook);
        checks++;
        if (lat !== 16 || !ook || {out, ovfl, zero} !== {16'h8000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL max_shift_ones: lat=%0d got %h/%b/%b, want 16 8000/0/0",
                     lat, out, ovfl, zero);
        end
    endtask

    task automatic test_min_operand;
        int lat; bit bok; bit ook;
        logic [15:0] exp_out;
        logic        exp_zero;
`ifdef SHIFT_SATURATE_EN
        exp_out  = 16'h8000;
        exp_zero = 1'b0;
`else
        exp_out  = 16'h0000;
        exp_zero = 1'b1;
`endif
        do_start(16'h8000, 4'd15);
        wait_done(16'h8000, lat, bok, ook);
        checks++;
        if (lat !== 16 || {out, ovfl, zero} !== {exp_out, 1'b1, exp_zero}) begin
            errors++;
            $display("FAIL min_operand: lat=%0d got %h/%b/%b, want 16 %h/1/%b",
                     lat, out, ovfl, zero, exp_out, exp_zero);
        end
    endtask

    task automatic test_ignore_start;
        int done_cyc;
        logic [15:0] prev;
        prev     = out;
        done_cyc = -1;
        do_start(16'h0001, 4'd8);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done && done_cyc < 0) done_cyc = i;
            if (i == 3) begin
                start = 1'b1;
                in    = 16'h1234;
                shamt = 4'd3;
            end else begin
                start = 1'b0;
            end
            if (done_cyc > 0) break;
        end
        start = 1'b0;
        checks++;
        if (done_cyc !== 9 || {out, ovfl, zero} !== {16'h0100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ignore_start: done at c+%0d got %h/%b/%b, want c+9 0100/0/0 (prev %h)",
                     done_cyc, out, ovfl, zero, prev);
        end
    endtask

    task automatic test_reset_mid;
        int lat; bit bok; bit ook; bit saw_done;
        do_start(16'h0001, 4'd8);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, out, ovfl, zero} !== 20'h0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b out=%h ovfl=%b zero=%b, want all 0",
                     busy, done, out, ovfl, zero);
        end
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: activity after reset=%b, want 0", saw_done);
        end
        do_start(16'h0007, 4'd3);
        wait_done(16'h0000, lat, bok, ook);
        checks++;
        if (lat !== 4 || {out, ovfl, zero} !== {16'h0038, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL after_reset: lat=%0d got %h/%b/%b, want 4 0038/0/0",
                     lat, out, ovfl, zero);
        end
    endtask

    task automatic test_back_to_back;
        int lat; bit bok; bit ook;
        do_start(16'h0003, 4'd4);
        wait_done(out, lat, bok, ook);
        // In the DONE cycle: request the next operation
        start = 1'b1;
        in    = 16'h0101;
        shamt = 4'd2;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(16'h0030, lat, bok, ook);
        checks++;
        if (lat !== 3 || !bok || !ook || {out, ovfl, zero} !== {16'h0404, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL back_to_back: lat=%0d busy_ok=%b held=%b got %h/%b/%b, want 3 1 1 0404/0/0",
                     lat, bok, ook, out, ovfl, zero);
        end
    endtask

    task automatic test_random;
        int lat; bit bok; bit ook;
        logic [15:0] a;
        logic [3:0]  s;
        logic [16:0] exp;
        logic [15:0] prev;
        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            if (n % 4 == 0) a = {{8{a[15]}}, a[7:0]};
            s    = 4'($urandom_range(0, 15));
            exp  = model(a, s);
            prev = out;
            do_start(a, s);
            wait_done(prev, lat, bok, ook);
            checks++;
            if (lat !== int'(s) + 1 || !bok || !ook || out !== exp[15:0] || ovfl !== exp[16]
                || zero !== (exp[15:0] == 16'h0)) begin
                errors++;
                $display("FAIL random in=%h sh=%0d: lat=%0d bok=%b ook=%b got %h/%b/%b, want lat=%0d %h/%b/%b",
                         a, s, lat, bok, ook, out, ovfl, zero, int'(s) + 1, exp[15:0], exp[16],
                         exp[15:0] == 16'h0);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        in     = '0;
        shamt  = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_overflow();
        test_zero_shift();
        test_min_operand();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
